// File: rtl/grf_wb_pkg.sv
// Shared types and constants for the register-file writeback front end.
// Imported by the FIFO, the interface and the arbiter top.
package grf_wb_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         REG_AW   = 5;
    localparam int         WB_WIDTH = 32;

    typedef struct packed {
        logic [REG_AW-1:0]   a3;
        logic [WB_WIDTH-1:0] wd;
    } wb_req_t;

    // A write to r0 is architecturally a no-op, so it never counts as a request.
    function automatic logic wb_live(input logic we, input logic [REG_AW-1:0] a3);
        return we && (a3 != REG_ZERO);
    endfunction

endpackage

// File: rtl/grf_wb_arbiter_if.sv
// Bundle of the W-stage, MDU, register-file and scoreboard signals around grf_wb_arbiter.
// master = surrounding pipeline, slave = arbiter.
interface grf_wb_arbiter_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
);
    import grf_wb_pkg::*;

    logic                   pipe_we;
    logic [REG_AW-1:0]      pipe_a3;
    logic [WIDTH-1:0]       pipe_wd;
    logic                   md_valid;
    logic                   md_ready;
    logic [REG_AW-1:0]      md_a3;
    logic [WIDTH-1:0]       md_wd;
    logic                   grf_we;
    logic [REG_AW-1:0]      grf_a3;
    logic [WIDTH-1:0]       grf_wd;
    logic [$clog2(DEPTH):0] count;
    logic [REG_AW-1:0]      pend_q;
    logic                   pend_hit;

    modport master (
        output pipe_we, pipe_a3, pipe_wd, md_valid, md_a3, md_wd, pend_q,
        input  md_ready, grf_we, grf_a3, grf_wd, count, pend_hit
    );

    modport slave (
        input  pipe_we, pipe_a3, pipe_wd, md_valid, md_a3, md_wd, pend_q,
        output md_ready, grf_we, grf_a3, grf_wd, count, pend_hit
    );

endinterface

// File: rtl/grf_wb_arbiter_wb_fifo.sv
// wb_fifo: circular buffer of MDU writeback requests, drained in arrival order.
// Exposes per-entry destination registers and a valid mask for the pending-write scoreboard.
module wb_fifo
    import grf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [REG_AW-1:0]      push_a3,
    input  logic [WIDTH-1:0]       push_wd,
    input  logic                   pop,
    output logic [REG_AW-1:0]      head_a3,
    output logic [WIDTH-1:0]       head_wd,
    output logic [$clog2(DEPTH):0] count,
    output logic [REG_AW-1:0]      entry_a3 [DEPTH],
    output logic [DEPTH-1:0]       entry_valid
);

    localparam int            PW   = $clog2(DEPTH);
    localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] ONE  = PW'(1);

    typedef struct packed {
        logic [REG_AW-1:0] a3;
        logic [WIDTH-1:0]  wd;
    } entry_t;

    entry_t          mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [PW:0]     count_r;
    logic [DEPTH-1:0] valid_r;
    logic            do_push_s;
    logic            do_pop_s;

    // Guard against overflow/underflow so the pointers and count never disagree.
    always_comb begin
        do_push_s = push && (count_r != FULL);
        do_pop_s  = pop && (count_r != (PW+1)'(0));
    end

    // Storage, pointers, occupancy and valid mask; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r]   <= '{a3: push_a3, wd: push_wd};
                valid_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r          <= wr_ptr_r + ONE;
            end
            if (do_pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head and entry views are read straight from registered storage.
    always_comb begin
        head_a3     = mem_r[rd_ptr_r].a3;
        head_wd     = mem_r[rd_ptr_r].wd;
        count       = count_r;
        entry_valid = valid_r;
        for (int i = 0; i < DEPTH; i++) begin
            entry_a3[i] = mem_r[i].a3;
        end
    end

endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: merges W-stage writes and queued MDU results onto the register-file write port.
// Optional pending-write scoreboard enabled by defining GRF_WB_SCOREBOARD_EN.
module grf_wb_arbiter
    import grf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    grf_wb_arbiter_if.slave         bus
);

    localparam int          CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic                   pipe_live_s;
    logic                   md_ready_s;
    logic                   md_push_s;
    logic                   pop_s;
    logic [REG_AW-1:0]      head_a3_s;
    logic [WIDTH-1:0]       head_wd_s;
    logic [CW-1:0]          count_s;
    logic                   grf_we_r;
    logic [REG_AW-1:0]      grf_a3_r;
    logic [WIDTH-1:0]       grf_wd_r;
    logic                   pend_hit_s;

`ifdef GRF_WB_SCOREBOARD_EN
    logic [REG_AW-1:0]      entry_a3_s [DEPTH];
    logic [DEPTH-1:0]       entry_valid_s;
`else
    logic [REG_AW-1:0]      sb_entry_a3_unused [DEPTH];
    logic [DEPTH-1:0]       sb_entry_valid_unused;
`endif

    // Ready is from registered occupancy only: a full queue refuses even when it pops this cycle.
    always_comb begin
        pipe_live_s = wb_live(bus.pipe_we, bus.pipe_a3);
        md_ready_s  = (count_s < FULL) && reset;
        md_push_s   = bus.md_valid && md_ready_s && (bus.md_a3 != REG_ZERO);
        pop_s       = !pipe_live_s && (count_s != CW'(0));
    end

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (md_push_s),
        .push_a3     (bus.md_a3),
        .push_wd     (bus.md_wd),
        .pop         (pop_s),
        .head_a3     (head_a3_s),
        .head_wd     (head_wd_s),
        .count       (count_s),
`ifdef GRF_WB_SCOREBOARD_EN
        .entry_a3    (entry_a3_s),
        .entry_valid (entry_valid_s)
`else
        .entry_a3    (sb_entry_a3_unused),
        .entry_valid (sb_entry_valid_unused)
`endif
    );

    // Write-port register: pipe has strict priority, queue head otherwise; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            grf_we_r <= 1'b0;
            grf_a3_r <= REG_ZERO;
            grf_wd_r <= '0;
        end else if (pipe_live_s) begin
            grf_we_r <= 1'b1;
            grf_a3_r <= bus.pipe_a3;
            grf_wd_r <= bus.pipe_wd;
        end else if (pop_s) begin
            grf_we_r <= 1'b1;
            grf_a3_r <= head_a3_s;
            grf_wd_r <= head_wd_s;
        end else begin
            grf_we_r <= 1'b0;
        end
    end

`ifdef GRF_WB_SCOREBOARD_EN
    // Hit if the queried register is queued or currently being written.
    always_comb begin
        pend_hit_s = 1'b0;
        if (bus.pend_q != REG_ZERO) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_valid_s[i] && (entry_a3_s[i] == bus.pend_q)) begin
                    pend_hit_s = 1'b1;
                end else begin
                    pend_hit_s = pend_hit_s;
                end
            end
            if (grf_we_r && (grf_a3_r == bus.pend_q)) begin
                pend_hit_s = 1'b1;
            end else begin
                pend_hit_s = pend_hit_s;
            end
        end else begin
            pend_hit_s = 1'b0;
        end
    end
`else
    assign pend_hit_s = 1'b0;
`endif

    assign bus.md_ready = md_ready_s;
    assign bus.count    = count_s;
    assign bus.grf_we   = grf_we_r;
    assign bus.grf_a3   = grf_a3_r;
    assign bus.grf_wd   = grf_wd_r;
    assign bus.pend_hit = pend_hit_s;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Testbench for grf_wb_arbiter: directed steps plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_grf_wb_arbiter;
    import grf_wb_pkg::*;

    localparam int DEPTH = 4;
`ifdef GRF_WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    grf_wb_arbiter_if #(.DEPTH(DEPTH), .WIDTH(32)) bus ();
    grf_wb_arbiter #(.DEPTH(DEPTH), .WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;

    wb_req_t     mq[$];
    logic        exp_we = 1'b0;
    logic [4:0]  exp_a3 = 5'd0;
    logic [31:0] exp_wd = 32'd0;
    bit          md_hold = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: check all outputs mid-cycle, then advance the reference model across the edge.
    task automatic cycle();
        bit rdy;
        bit hit;
        wb_req_t e;
        @(negedge clk);
        rdy = reset && (mq.size() < DEPTH);
        hit = 1'b0;
        if (SB && bus.pend_q != 5'd0) begin
            foreach (mq[i]) if (mq[i].a3 == bus.pend_q) hit = 1'b1;
            if (exp_we && exp_a3 == bus.pend_q) hit = 1'b1;
        end
        chk("grf_we", bus.grf_we, exp_we);
        chk("grf_a3", bus.grf_a3, exp_a3);
        chk("grf_wd", bus.grf_wd, exp_wd);
        chk("count", bus.count, mq.size());
        chk("md_ready", bus.md_ready, rdy);
        chk("pend_hit", bus.pend_hit, hit);
        md_hold = bus.md_valid && !rdy;
        if (!reset) begin
            mq.delete();
            exp_we = 1'b0; exp_a3 = 5'd0; exp_wd = 32'd0;
        end else begin
            if (bus.pipe_we && bus.pipe_a3 != 5'd0) begin
                exp_we = 1'b1; exp_a3 = bus.pipe_a3; exp_wd = bus.pipe_wd;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                exp_we = 1'b1; exp_a3 = e.a3; exp_wd = e.wd;
            end else begin
                exp_we = 1'b0;
            end
            if (bus.md_valid && rdy && bus.md_a3 != 5'd0)
                mq.push_back('{a3: bus.md_a3, wd: bus.md_wd});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.pipe_we = 1'b0; bus.pipe_a3 = 5'd0; bus.pipe_wd = 32'd0;
        bus.md_valid = 1'b0; bus.md_a3 = 5'd0; bus.md_wd = 32'd0;
        bus.pend_q = 5'd0;
        @(posedge clk); #1;

        // Reset with both sources requesting.
        bus.md_valid = 1'b1; bus.md_a3 = 5'd4; bus.md_wd = 32'h44;
        bus.pipe_we = 1'b1; bus.pipe_a3 = 5'd7; bus.pipe_wd = 32'h77;
        cycle(); cycle();
        chk("reset_count", bus.count, 32'd0);
        chk("reset_ready", bus.md_ready, 32'd0);
        reset = 1'b1; bus.md_valid = 1'b0; bus.pipe_we = 1'b0;
        #1 chk("ready_after_reset", bus.md_ready, 32'd1);
        cycle();

        // Pipe pass-through and r0 suppression.
        bus.pipe_we = 1'b1; bus.pipe_a3 = 5'd5; bus.pipe_wd = 32'h12345678;
        cycle();
        chk("pipe_we", bus.grf_we, 32'd1);
        chk("pipe_a3", bus.grf_a3, 32'd5);
        chk("pipe_wd", bus.grf_wd, 32'h12345678);
        bus.pipe_we = 1'b0;
        cycle();
        chk("pipe_we_off", bus.grf_we, 32'd0);
        bus.pipe_we = 1'b1; bus.pipe_a3 = 5'd0;
        cycle();
        chk("pipe_r0", bus.grf_we, 32'd0);
        bus.pipe_we = 1'b0;

        // MDU queue and drain, two-cycle latency.
        bus.md_valid = 1'b1; bus.md_a3 = 5'd8; bus.md_wd = 32'hA;
        cycle();
        bus.md_a3 = 5'd9; bus.md_wd = 32'hB;
        cycle();
        chk("mdu_first_a3", bus.grf_a3, 32'd8);
        chk("mdu_first_wd", bus.grf_wd, 32'hA);
        bus.md_valid = 1'b0;
        cycle();
        chk("mdu_second_a3", bus.grf_a3, 32'd9);
        cycle();
        chk("mdu_drained", bus.count, 32'd0);

        // Pipe busy while offering five MDU results, then release.
        k = 0;
        bus.md_valid = 1'b1; bus.md_a3 = 5'd10; bus.md_wd = 32'h100;
        for (int i = 0; i < 16; i++) begin
            bus.pipe_we = (i < 8); bus.pipe_a3 = 5'((i % 31) + 1); bus.pipe_wd = $urandom;
            cycle();
            if (i == 7) begin
                chk("full_count", bus.count, 32'd4);
                chk("full_ready", bus.md_ready, 32'd0);
            end
            if (bus.md_valid && !md_hold) begin
                k++;
                if (k < 5) begin
                    bus.md_a3 = 5'(10 + k); bus.md_wd = 32'h100 + 32'(k);
                end else begin
                    bus.md_valid = 1'b0;
                end
            end
        end
        chk("fifth_issued_last", bus.grf_a3, 32'd14);

        // Interleaved pushes and pops across the pointer wrap.
        bus.md_valid = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (!md_hold) begin
                bus.md_valid = (i % 2 == 0);
                bus.md_a3 = 5'($urandom_range(1, 31)); bus.md_wd = $urandom;
            end
            bus.pipe_we = (i % 3 == 0); bus.pipe_a3 = 5'($urandom_range(1, 31));
            bus.pipe_wd = $urandom;
            cycle();
            chk("count_le_depth", 32'(bus.count <= 4), 32'd1);
        end
        bus.md_valid = 1'b0; bus.pipe_we = 1'b0;
        repeat (6) cycle();

        // Scoreboard query on a queued register.
        bus.pend_q = 5'd3;
        bus.md_valid = 1'b1; bus.md_a3 = 5'd3; bus.md_wd = 32'h33;
        bus.pipe_we = 1'b1; bus.pipe_a3 = 5'd1;
        cycle();
        bus.md_valid = 1'b0;
        #1 chk("pend_queued", bus.pend_hit, 32'(SB));
        bus.pipe_we = 1'b0;
        cycle();
        chk("pend_on_port", bus.pend_hit, 32'(SB));
        cycle();
        chk("pend_cleared", bus.pend_hit, 32'd0);
        bus.pend_q = 5'd0;
        #1 chk("pend_r0", bus.pend_hit, 32'd0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 63) != 0);
            if (!md_hold) begin
                bus.md_valid = ($urandom_range(0, 9) < 6);
                bus.md_a3 = 5'($urandom_range(0, 31)); bus.md_wd = $urandom;
            end
            bus.pipe_we = $urandom_range(0, 1);
            bus.pipe_a3 = 5'($urandom_range(0, 31)); bus.pipe_wd = $urandom;
            bus.pend_q = 5'($urandom_range(0, 31));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
